// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - ALU op encodings and arbiter FSM state type
package alu_defs;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - 32-bit combinational ALU selected by aluc
module alu
    import alu_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] r
);

    // Only aluc[2:0] picks the op; aluc[3] only splits SRL from SRA, so unused codes alias.
    always_comb begin
        r = '0;
        case (aluc[2:0])
            ALU_ADD[2:0]: r = a + b;
            ALU_SUB[2:0]: r = a - b;
            ALU_AND[2:0]: r = a & b;
            ALU_OR[2:0]:  r = a | b;
            ALU_XOR[2:0]: r = a ^ b;
            ALU_LUI[2:0]: r = {b[15:0], 16'h0000};
            ALU_SLL[2:0]: r = b << a[4:0];
            ALU_SRL[2:0]: begin
                if (aluc[3])
                    r = $signed(b) >>> a[4:0];
                else
                    r = b >> a[4:0];
            end
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arb.sv
// rtl/alu_share_arbiter_rr_arb.sv - round-robin arbiter searching upward from ptr
module rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                off;
    int                sum;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        any = 1'b0;
        off = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                off = k;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NREQ)
            sum = sum - NREQ;
        idx = IDW'(sum);
        gnt = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by NREQ requesters; ALU_ARB_STATS_EN adds grant counters
module alu_share_arbiter
    import alu_defs::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_aluc,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_r,
    output logic                 rsp_z,
    output logic [IDW-1:0]       rsp_id,
    output logic [NREQ*16-1:0]   grant_cnt
);

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  w_idx;
    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic            accept_ok;
    logic            grant;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [3:0]      sel_aluc;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [3:0]      op_aluc;
    logic [IDW-1:0]  op_id;
    logic [31:0]     alu_r;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    alu u_alu (
        .a    (op_a),
        .b    (op_b),
        .aluc (op_aluc),
        .r    (alu_r)
    );

    // clrn gates accept so req_ready drops the moment reset asserts.
    assign accept_ok = clrn & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign req_ready = accept_ok ? w_gnt : '0;
    assign grant     = accept_ok & w_any;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_aluc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                sel_a    = req_a[32*i +: 32];
                sel_b    = req_b[32*i +: 32];
                sel_aluc = req_aluc[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_aluc   <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_z     <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (grant) begin
                op_a    <= sel_a;
                op_b    <= sel_b;
                op_aluc <= sel_aluc;
                op_id   <= w_idx;
                ptr     <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant)
                        state <= EXEC;
                end
                EXEC: begin
                    rsp_r     <= alu_r;
                    rsp_z     <= ~|alu_r;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= grant ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn)
                cnt <= '0;
            else if (grant && w_gnt[i] && (cnt != 16'hFFFF))
                cnt <= cnt + 16'd1;
        end
        assign grant_cnt[16*i +: 16] = cnt;
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter (NREQ=2)
module tb_alu_share_arbiter;
    import alu_defs::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic               clk;
    logic               clrn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*4-1:0]  req_aluc;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_r;
    logic               rsp_z;
    logic [IDW-1:0]     rsp_id;
    logic [NREQ*16-1:0] grant_cnt;

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_aluc  (req_aluc),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .grant_cnt (grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_aluc[4*i +: 4] = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    initial begin
        clrn      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_aluc  = '0;
        rsp_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_cnt", grant_cnt, 0);
        chk("rst_rsp_r", rsp_r, 0);
        clrn = 1'b1;
        step();

        // Contention: req0 SUB 9-9 wins first, then req1 SRA
        set_req(0, 1'b1, ALU_SUB, 32'd9, 32'd9);
        set_req(1, 1'b1, ALU_SRA, 32'd4, 32'h8000_0000);
        #1;
        chk("cont_first_grant", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        #1;
        chk("cont_exec_ready", req_ready, 0);
        chk("cont_exec_valid", rsp_valid, 0);
        step();
        chk("cont_r0_valid", rsp_valid, 1);
        chk("cont_r0_id", rsp_id, 0);
        chk("cont_r0_r", rsp_r, 32'h0);
        chk("cont_r0_z", rsp_z, 1);
        chk("cont_r0_ready_hold", req_ready, 0);
        rsp_ready = 1'b1;
        #1;
        chk("cont_b2b_grant", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b0;
        #1;
        chk("cont_exec2_valid", rsp_valid, 0);
        step();
        chk("cont_r1_valid", rsp_valid, 1);
        chk("cont_r1_id", rsp_id, 1);
        chk("cont_r1_r", rsp_r, 32'hF800_0000);
        chk("cont_r1_z", rsp_z, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("cont_done_valid", rsp_valid, 0);

        // Fairness: both valid, consumer always ready, 8 grants alternate 0,1,...
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        set_req(1, 1'b1, ALU_XOR, 32'hFF, 32'h0F);
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 8; g++) begin
            int waitc;
            waitc = 0;
            while (req_ready == '0 && waitc < 4) begin
                step();
                waitc++;
            end
            chk($sformatf("fair_grant%0d", g), req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            if (g > 0)
                chk($sformatf("fair_rsp_id%0d", g), rsp_id, (g - 1) % 2);
            step();
        end
        req_valid = '0;
        step();
        chk("fair_last_valid", rsp_valid, 1);
        chk("fair_last_id", rsp_id, 1);
        step();
        rsp_ready = 1'b0;
        chk("fair_idle_valid", rsp_valid, 0);
`ifdef ALU_ARB_STATS_EN
        chk("fair_grant_cnt", grant_cnt, 32'h0005_0005);
`else
        chk("fair_grant_cnt", grant_cnt, 32'h0);
`endif

        // Single op: req0 ADD 5+7, response two cycles after accept
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        #1;
        chk("single_grant", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        #1;
        chk("single_t1_valid", rsp_valid, 0);
        step();
        chk("single_valid", rsp_valid, 1);
        chk("single_r", rsp_r, 32'd12);
        chk("single_z", rsp_z, 0);
        chk("single_id", rsp_id, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Backpressure: response held 5 cycles while req0 waits
        set_req(1, 1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        chk("bp_grant", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, ALU_OR, 32'd1, 32'd2);
        #1;
        chk("bp_exec_ready", req_ready, 0);
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold_valid%0d", c), rsp_valid, 1);
            chk($sformatf("bp_hold_r%0d", c), rsp_r, 32'h0000_F000);
            chk($sformatf("bp_hold_id%0d", c), rsp_id, 1);
            chk($sformatf("bp_hold_ready%0d", c), req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_accept_on_ready", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        rsp_ready    = 1'b0;
        #1;
        chk("bp_exec2_valid", rsp_valid, 0);
        step();
        chk("bp_r2_valid", rsp_valid, 1);
        chk("bp_r2_r", rsp_r, 32'd3);
        chk("bp_r2_id", rsp_id, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset with an op in EXEC: op dropped, pointer back to 0
        set_req(1, 1'b1, ALU_SUB, 32'd10, 32'd3);
        #1;
        chk("rx_grant", req_ready, 2'b10);
        step();
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        clrn = 1'b0;
        #1;
        chk("rx_rsp_valid", rsp_valid, 0);
        chk("rx_req_ready", req_ready, 0);
        chk("rx_grant_cnt", grant_cnt, 0);
        step();
        step();
        clrn = 1'b1;
        #1;
        chk("rx_first_grant_req0", req_ready, 2'b01);
        req_valid = '0;
        #1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rx_no_rsp%0d", c), rsp_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
